ex_mem_pipe_reg: RTL and testbench
==================================

# ex_mem_pipe_reg

Parametrised EX/MEM pipeline register with a valid/ready handshake, a two-entry skid buffer, and synchronous flush. It sits between the execute stage and the memory stage. It carries the ALU result, store data (bus B), destination register, memory control and write-back control. It generalises the plain write-enabled stage latch: the stage can back-pressure, the upstream ready signal is registered, and control fields are masked on bubbles.

## Interface
- DATA_W, 32, width of ALU result and store data
- REG_ADDR_W, 5, destination register address width
- MEM_CTRL_W, 5, memory control field width
- WR_CTRL_W, 2, write-back control field width
- CNT_W, 16, stall counter width (only used with EXMEM_PERF_CNT_EN)

- clk  input  1  stage clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous kill of all held entries
- in_valid  input  1  EX stage offers an entry
- in_ready  output  1  stage can accept; registered
- alu_result_ex  input  DATA_W  ALU result
- bus_b_ex  input  DATA_W  store data
- rw_ex  input  REG_ADDR_W  destination register
- mem_ctrl_ex  input  MEM_CTRL_W  memory control
- wr_ctrl_ex  input  WR_CTRL_W  write-back control
- out_valid  output  1  MEM entry valid
- out_ready  input  1  MEM stage consumes entry
- alu_result_mem, bus_b_mem, rw_mem  output  DATA_W/DATA_W/REG_ADDR_W  held payload
- mem_ctrl_mem  output  MEM_CTRL_W  control, forced 0 when !out_valid
- wr_ctrl_mem  output  WR_CTRL_W  control, forced 0 when !out_valid
- stall_cnt  output  CNT_W  saturating stall count (macro only)

## Operation
- Storage: main entry (drives outputs) and skid entry, each with a valid bit.
- Accept when in_valid && in_ready. Consume when out_valid && out_ready.
- in_ready = !skid_valid, taken from the flop directly with no combinational path from out_ready.
- Main entry update, in priority order:
  - flush: main_valid=0.
  - If consume or !main_valid: main <- skid if skid_valid, else the input if accepted, else main_valid=0.
  - Otherwise main holds.
- Skid entry update:
  - flush: skid_valid=0.
  - Accept while main is valid, is not consumed, and skid is empty: skid <- input.
  - Skid is drained into main on consume.
- Accept and consume in the same cycle with skid empty: pass-through. Main takes the input and skid stays empty.
- Ordering is strictly FIFO. The skid entry is never overtaken.
- flush has highest priority. An entry accepted in the flush cycle is dropped. in_ready stays 1 because skid_valid was 0 or is cleared.
- Payload registers load only on a data move. They never change while their valid bit holds.
- Bubble masking: mem_ctrl_mem and wr_ctrl_mem read 0 whenever out_valid=0, so MEM and WB never act on stale control.

## Timing
- Reset (rst_n low, asynchronous): main_valid=0, skid_valid=0, in_ready=1, out_valid=0, all payload outputs 0, stall_cnt=0.
- Latency: an entry accepted at edge N is visible with out_valid=1 after edge N.
- Throughput: 1 entry/cycle sustained while out_ready=1.
- Back-pressure: after out_ready drops, at most one more entry is accepted (into skid). in_ready falls after that edge.
- in_ready returns to 1 the edge after skid drains.
- Release of rst_n is synchronous to clk. The first accept is possible on the first edge with rst_n high.

## Configuration
- EXMEM_PERF_CNT_EN defined:
  - stall_cnt is present.
  - It increments on every edge where out_valid && !out_ready.
  - It saturates at 2^CNT_W-1.
  - It is cleared only by rst_n; flush does not clear it.
- EXMEM_PERF_CNT_EN undefined:
  - stall_cnt port and counter logic are absent.
  - The CNT_W parameter is ignored.

## Test plan
- Reset mid-stream: hold out_ready=0 with two entries held, then pulse rst_n low. Required: out_valid=0, in_ready=1, wr_ctrl_mem=0 immediately, without waiting for a clock edge.
- Streaming: out_ready=1, send alu_result 1..8 on consecutive cycles. Required: out_valid from cycle 1, outputs 1..8 in order, in_ready always 1.
- Back-pressure: send A=0x10 and B=0x20, then C=0x30, with out_ready=0 from the cycle A appears at the output. Required:
  - skid holds B and in_ready=0; C is not accepted.
  - Raising out_ready yields A, then B, then C; no loss or duplication.
- Flush: with main=0x10 and skid=0x20, assert flush together with in_valid carrying 0x30. Required: the next cycle has out_valid=0, mem_ctrl_mem=0, wr_ctrl_mem=0, in_ready=1, and 0x30 never appears.
- Bubble masking: present wr_ctrl_ex=2'b11, then let the entry be consumed with no new input. Required: wr_ctrl_mem=2'b11 while out_valid=1, and 0 when out_valid=0. rw_mem keeps its last value.
- Counter (EXMEM_PERF_CNT_EN, CNT_W=4): stall for 20 cycles. Required: stall_cnt=15 (saturated), unchanged by flush, 0 after reset.

Source files
------------

// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline register: valid/ready handshake, two-entry skid buffer, synchronous flush.
// Optional saturating stall counter enabled by defining EXMEM_PERF_CNT_EN.
module ex_mem_pipe_reg #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int MEM_CTRL_W = 5,
    parameter int WR_CTRL_W  = 2,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     alu_result_ex,
    input  logic [DATA_W-1:0]     bus_b_ex,
    input  logic [REG_ADDR_W-1:0] rw_ex,
    input  logic [MEM_CTRL_W-1:0] mem_ctrl_ex,
    input  logic [WR_CTRL_W-1:0]  wr_ctrl_ex,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     alu_result_mem,
    output logic [DATA_W-1:0]     bus_b_mem,
    output logic [REG_ADDR_W-1:0] rw_mem,
    output logic [MEM_CTRL_W-1:0] mem_ctrl_mem,
    output logic [WR_CTRL_W-1:0]  wr_ctrl_mem
`ifdef EXMEM_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]      stall_cnt
`endif
);

    typedef struct packed {
        logic [DATA_W-1:0]     alu_result;
        logic [DATA_W-1:0]     bus_b;
        logic [REG_ADDR_W-1:0] rw;
        logic [MEM_CTRL_W-1:0] mem_ctrl;
        logic [WR_CTRL_W-1:0]  wr_ctrl;
    } entry_t;

    entry_t r_main;
    entry_t r_skid;
    logic   r_main_valid;
    logic   r_skid_valid;

    entry_t w_in_entry;
    logic   w_accept;
    logic   w_consume;

    assign w_in_entry = '{alu_result: alu_result_ex, bus_b: bus_b_ex, rw: rw_ex,
                          mem_ctrl: mem_ctrl_ex, wr_ctrl: wr_ctrl_ex};

    // in_ready comes straight off the skid valid flop, so out_ready never reaches it combinationally.
    assign in_ready  = ~r_skid_valid;
    assign w_accept  = in_valid && in_ready;
    assign w_consume = r_main_valid && out_ready;

    // NOTE: payload registers are reset too, because the outputs must read 0 straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_main       <= '0;
            r_skid       <= '0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_consume || !r_main_valid) begin
            if (r_skid_valid) begin
                r_main       <= r_skid;
                r_main_valid <= 1'b1;
                r_skid_valid <= 1'b0;
            end else if (w_accept) begin
                r_main       <= w_in_entry;
                r_main_valid <= 1'b1;
            end else begin
                r_main_valid <= 1'b0;
            end
        end else if (w_accept) begin
            // Main is held and the skid is empty (accept implies it): park the input behind main.
            r_skid       <= w_in_entry;
            r_skid_valid <= 1'b1;
        end
    end

    assign out_valid      = r_main_valid;
    assign alu_result_mem = r_main.alu_result;
    assign bus_b_mem      = r_main.bus_b;
    assign rw_mem         = r_main.rw;
    assign mem_ctrl_mem   = r_main_valid ? r_main.mem_ctrl : '0;
    assign wr_ctrl_mem    = r_main_valid ? r_main.wr_ctrl  : '0;

`ifdef EXMEM_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;

    // Only rst_n clears the counter; flush deliberately leaves it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (r_main_valid && !out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    // Without the counter CNT_W has no effect.
    if (CNT_W < 1) begin : g_cnt_w_ignored
    end
`endif

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Self-checking bench for ex_mem_pipe_reg: directed scenarios then random traffic,
// every cycle compared against a two-deep FIFO reference model.
module tb_ex_mem_pipe_reg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int MEM_CTRL_W = 5;
    localparam int WR_CTRL_W  = 2;
    localparam int CNT_W      = 4;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    logic                  clk;
    logic                  rst_n;
    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_W-1:0]     alu_result_ex;
    logic [DATA_W-1:0]     bus_b_ex;
    logic [REG_ADDR_W-1:0] rw_ex;
    logic [MEM_CTRL_W-1:0] mem_ctrl_ex;
    logic [WR_CTRL_W-1:0]  wr_ctrl_ex;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_W-1:0]     alu_result_mem;
    logic [DATA_W-1:0]     bus_b_mem;
    logic [REG_ADDR_W-1:0] rw_mem;
    logic [MEM_CTRL_W-1:0] mem_ctrl_mem;
    logic [WR_CTRL_W-1:0]  wr_ctrl_mem;
`ifdef EXMEM_PERF_CNT_EN
    logic [CNT_W-1:0]      stall_cnt;
`endif

    ex_mem_pipe_reg #(
        .DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .MEM_CTRL_W(MEM_CTRL_W),
        .WR_CTRL_W(WR_CTRL_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_result_ex(alu_result_ex), .bus_b_ex(bus_b_ex), .rw_ex(rw_ex),
        .mem_ctrl_ex(mem_ctrl_ex), .wr_ctrl_ex(wr_ctrl_ex),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_result_mem(alu_result_mem), .bus_b_mem(bus_b_mem), .rw_mem(rw_mem),
        .mem_ctrl_mem(mem_ctrl_mem), .wr_ctrl_mem(wr_ctrl_mem)
`ifdef EXMEM_PERF_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [DATA_W-1:0]     alu;
        logic [DATA_W-1:0]     bus;
        logic [REG_ADDR_W-1:0] rw;
        logic [MEM_CTRL_W-1:0] mem;
        logic [WR_CTRL_W-1:0]  wr;
    } entry_t;

    // Reference model: the stage behaves as a two-deep FIFO whose head drives the outputs.
    entry_t q[$];
    entry_t held;
    int     exp_cnt;
    int     vectors;
    int     miscompares;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        entry_t h;
        bit     v;
        v = (q.size() > 0);
        h = v ? q[0] : held;
        check("out_valid", 64'(out_valid), 64'(v));
        check("in_ready", 64'(in_ready), 64'(q.size() < 2));
        check("alu_result_mem", 64'(alu_result_mem), 64'(h.alu));
        check("bus_b_mem", 64'(bus_b_mem), 64'(h.bus));
        check("rw_mem", 64'(rw_mem), 64'(h.rw));
        check("mem_ctrl_mem", 64'(mem_ctrl_mem), v ? 64'(h.mem) : 64'd0);
        check("wr_ctrl_mem", 64'(wr_ctrl_mem), v ? 64'(h.wr) : 64'd0);
`ifdef EXMEM_PERF_CNT_EN
        check("stall_cnt", 64'(stall_cnt), 64'(exp_cnt));
`endif
    endtask

    // Advance the model by one edge using the inputs currently applied, then compare after the edge.
    task automatic tick();
        entry_t e;
        int     n;
        bit     acc;
        bit     cons;
        n    = q.size();
        acc  = in_valid && (n < 2);
        cons = out_ready && (n > 0);
        e    = '{alu: alu_result_ex, bus: bus_b_ex, rw: rw_ex, mem: mem_ctrl_ex, wr: wr_ctrl_ex};
        if (n > 0 && !out_ready && exp_cnt < CNT_MAX) exp_cnt++;
        if (n > 0) held = q[0];
        if (flush) begin
            q.delete();
        end else begin
            if (cons) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
        if (q.size() > 0) held = q[0];
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic drive(input bit v, input logic [DATA_W-1:0] a, input logic [REG_ADDR_W-1:0] r,
                         input logic [MEM_CTRL_W-1:0] m, input logic [WR_CTRL_W-1:0] w);
        in_valid      = v;
        alu_result_ex = a;
        bus_b_ex      = ~a;
        rw_ex         = r;
        mem_ctrl_ex   = m;
        wr_ctrl_ex    = w;
    endtask

    // Asynchronous reset assertion in mid-cycle, release just after a falling edge.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        q.delete();
        held    = '0;
        exp_cnt = 0;
        #1;
        check("rst_async_out_valid", 64'(out_valid), 64'd0);
        check("rst_async_in_ready", 64'(in_ready), 64'd1);
        check("rst_async_wr_ctrl", 64'(wr_ctrl_mem), 64'd0);
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        exp_cnt     = 0;
        held        = '0;
        rst_n       = 1'b0;
        flush       = 1'b0;
        out_ready   = 1'b1;
        drive(1'b0, '0, '0, '0, '0);
        #1;
        check_all();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_all();

        // Streaming 1..8 with the sink always ready.
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, DATA_W'(i), REG_ADDR_W'(i), MEM_CTRL_W'(i), WR_CTRL_W'(i));
            tick();
            check("stream_value", 64'(alu_result_mem), 64'(i));
            check("stream_in_ready", 64'(in_ready), 64'd1);
        end
        drive(1'b0, '0, '0, '0, '0);
        tick();

        // Back-pressure: A enters main, B goes to skid, C must wait.
        drive(1'b1, 32'h10, 5'd1, 5'h11, 2'd1);
        out_ready = 1'b0;
        tick();
        drive(1'b1, 32'h20, 5'd2, 5'h12, 2'd2);
        tick();
        check("bp_in_ready_low", 64'(in_ready), 64'd0);
        drive(1'b1, 32'h30, 5'd3, 5'h13, 2'd3);
        tick();
        check("bp_hold_a", 64'(alu_result_mem), 64'h10);
        out_ready = 1'b1;
        tick();
        check("bp_then_b", 64'(alu_result_mem), 64'h20);
        tick();
        check("bp_then_c", 64'(alu_result_mem), 64'h30);
        drive(1'b0, '0, '0, '0, '0);
        tick();
        check("bp_drained", 64'(out_valid), 64'd0);

        // Flush with main and skid full while a new entry is offered.
        out_ready = 1'b0;
        drive(1'b1, 32'h10, 5'd4, 5'h1f, 2'd3);
        tick();
        drive(1'b1, 32'h20, 5'd5, 5'h1e, 2'd2);
        tick();
        drive(1'b1, 32'h30, 5'd6, 5'h1d, 2'd1);
        flush = 1'b1;
        tick();
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_in_ready", 64'(in_ready), 64'd1);
        check("flush_mem_ctrl", 64'(mem_ctrl_mem), 64'd0);
        flush     = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, '0, '0, '0, '0);
        repeat (3) begin
            tick();
            check("flush_no_ghost", 64'(out_valid), 64'd0);
        end

        // Bubble masking of control, payload retained.
        drive(1'b1, 32'h55, 5'd7, 5'h0a, 2'b11);
        tick();
        check("bubble_wr_valid", 64'(wr_ctrl_mem), 64'd3);
        drive(1'b0, '0, '0, '0, '0);
        tick();
        check("bubble_wr_masked", 64'(wr_ctrl_mem), 64'd0);
        check("bubble_rw_kept", 64'(rw_mem), 64'd7);

`ifdef EXMEM_PERF_CNT_EN
        // Stall counter saturation, immune to flush.
        out_ready = 1'b0;
        drive(1'b1, 32'h77, 5'd9, 5'h01, 2'd1);
        tick();
        drive(1'b0, '0, '0, '0, '0);
        repeat (20) tick();
        check("cnt_saturated", 64'(stall_cnt), 64'(CNT_MAX));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("cnt_after_flush", 64'(stall_cnt), 64'(CNT_MAX));
        do_reset();
        check("cnt_after_reset", 64'(stall_cnt), 64'd0);
`endif

        // Reset mid-stream with two entries held.
        out_ready = 1'b0;
        drive(1'b1, 32'ha1, 5'd10, 5'h03, 2'd3);
        tick();
        drive(1'b1, 32'ha2, 5'd11, 5'h04, 2'd2);
        tick();
        drive(1'b0, '0, '0, '0, '0);
        do_reset();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), DATA_W'($urandom), REG_ADDR_W'($urandom),
                  MEM_CTRL_W'($urandom), WR_CTRL_W'($urandom));
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            tick();
        end
        flush = 1'b0;
        drive(1'b0, '0, '0, '0, '0);
        out_ready = 1'b1;
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
